// File: rtl/nebula_axil_master_if.sv
// AXI-Lite initiator bus bundle: combined AW+W request, AR request, B and R responses.
interface nebula_axil_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  m_aw_valid;
  logic                  m_aw_ready;
  logic [ADDR_W-1:0]     m_aw_addr;
  logic [DATA_W-1:0]     m_aw_data;
  logic [DATA_W/8-1:0]   m_aw_strb;
  logic                  m_b_valid;
  logic                  m_b_ready;
  logic [1:0]            m_b_resp;
  logic                  m_ar_valid;
  logic                  m_ar_ready;
  logic [ADDR_W-1:0]     m_ar_addr;
  logic                  m_r_valid;
  logic                  m_r_ready;
  logic [DATA_W-1:0]     m_r_data;
  logic [1:0]            m_r_resp;

  modport master (
    output m_aw_valid, m_aw_addr, m_aw_data, m_aw_strb,
    input  m_aw_ready,
    input  m_b_valid, m_b_resp,
    output m_b_ready,
    output m_ar_valid, m_ar_addr,
    input  m_ar_ready,
    input  m_r_valid, m_r_data, m_r_resp,
    output m_r_ready
  );

  modport slave (
    input  m_aw_valid, m_aw_addr, m_aw_data, m_aw_strb,
    output m_aw_ready,
    output m_b_valid, m_b_resp,
    input  m_b_ready,
    input  m_ar_valid, m_ar_addr,
    output m_ar_ready,
    output m_r_valid, m_r_data, m_r_resp,
    input  m_r_ready
  );
endinterface

// File: rtl/nebula_axil_master.sv
// Single-outstanding AXI-Lite initiator turning cmd/rsp requests into bus transactions.
// Optional abort-on-timeout enabled by defining NEBULA_AXIL_MST_TIMEOUT_EN.
module nebula_axil_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_strb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic [1:0]          rsp_resp_o,
  output logic                rsp_timeout_o,
  output logic                busy_o,
  nebula_axil_master_if.master m_axi
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   strb_q, strb_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  tmo_q, tmo_d;
  logic                  cmd_ready_q, rsp_valid_q, busy_q;
  logic                  aw_valid_q, b_ready_q, ar_valid_q, r_ready_q;
  logic                  accept_s, done_s, tmo_hit_s;

  assign accept_s = (state_q == IDLE) && cmd_valid_i && cmd_ready_q;
  assign done_s   = ((state_q == WR_RESP) && m_axi.m_b_valid) ||
                    ((state_q == RD_DATA) && m_axi.m_r_valid);

`ifdef NEBULA_AXIL_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_flight_s;

  assign in_flight_s = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                       (state_q == RD_REQ) || (state_q == RD_DATA);
  // A response beat in the final cycle still completes normally.
  assign tmo_hit_s = in_flight_s && !done_s &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cycles spent waiting on the bus since the command was accepted.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_s) begin
      cnt_d = '0;
    end else if (in_flight_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state and latch-enable decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    tmo_d   = tmo_q;
    if (tmo_hit_s) begin
      state_d = RSP;
      rdata_d = '0;
      resp_d  = 2'b10;
      tmo_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            addr_d  = cmd_addr_i;
            wdata_d = cmd_wdata_i;
            strb_d  = cmd_strb_i;
            state_d = cmd_write_i ? WR_REQ : RD_REQ;
          end else begin
            state_d = IDLE;
          end
        end
        WR_REQ: begin
          if (m_axi.m_aw_ready) state_d = WR_RESP;
          else                  state_d = WR_REQ;
        end
        WR_RESP: begin
          if (m_axi.m_b_valid) begin
            rdata_d = '0;
            resp_d  = m_axi.m_b_resp;
            tmo_d   = 1'b0;
            state_d = RSP;
          end else begin
            state_d = WR_RESP;
          end
        end
        RD_REQ: begin
          if (m_axi.m_ar_ready) state_d = RD_DATA;
          else                  state_d = RD_REQ;
        end
        RD_DATA: begin
          if (m_axi.m_r_valid) begin
            rdata_d = m_axi.m_r_data;
            resp_d  = m_axi.m_r_resp;
            tmo_d   = 1'b0;
            state_d = RSP;
          end else begin
            state_d = RD_DATA;
          end
        end
        RSP: begin
          if (rsp_ready_i) state_d = IDLE;
          else             state_d = RSP;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, payload and output flops; handshake outputs follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
      tmo_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      aw_valid_q  <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      tmo_q       <= tmo_d;
      cmd_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RSP);
      busy_q      <= (state_d != IDLE);
      aw_valid_q  <= (state_d == WR_REQ);
      b_ready_q   <= (state_d == WR_RESP);
      ar_valid_q  <= (state_d == RD_REQ);
      r_ready_q   <= (state_d == RD_DATA);
    end
  end

  assign cmd_ready_o      = cmd_ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_rdata_o      = rdata_q;
  assign rsp_resp_o       = resp_q;
  assign rsp_timeout_o    = tmo_q;
  assign busy_o           = busy_q;
  assign m_axi.m_aw_valid = aw_valid_q;
  assign m_axi.m_aw_addr  = addr_q;
  assign m_axi.m_aw_data  = wdata_q;
  assign m_axi.m_aw_strb  = strb_q;
  assign m_axi.m_b_ready  = b_ready_q;
  assign m_axi.m_ar_valid = ar_valid_q;
  assign m_axi.m_ar_addr  = addr_q;
  assign m_axi.m_r_ready  = r_ready_q;
endmodule

// File: tb/tb_nebula_axil_master.sv
// Directed bench for nebula_axil_master: memory-backed slave, response scoreboard, per-cycle monitor.
`timescale 1ns/1ps
module tb_nebula_axil_master;
`ifdef NEBULA_AXIL_MST_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif
  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout, busy;

  nebula_axil_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  nebula_axil_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_resp_o(rsp_resp), .rsp_timeout_o(rsp_timeout), .busy_o(busy),
    .m_axi(axi)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  rsp_t        exp_q[$];
  logic [31:0] model_mem [16];
  logic [31:0] slv_mem [16];
  logic        cur_write = 1'b0;
  logic [31:0] cur_addr = 32'd0, cur_wdata = 32'd0;
  logic [3:0]  cur_strb = 4'd0;
  logic        outstanding = 1'b0;
  int          b_delay = 0, r_delay = 0;
  logic [1:0]  b_resp_val = 2'b00, r_resp_val = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic abort(input string what);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", what);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "run stopped");
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic rsp_t wr_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    model_mem[a[5:2]] = merge(model_mem[a[5:2]], d, s);
    return {32'd0, b_resp_val, 1'b0};
  endfunction

  function automatic rsp_t rd_exp(input logic [31:0] a);
    return {model_mem[a[5:2]], r_resp_val, 1'b0};
  endfunction

  // Slave: memory behind the bus, responses delayed by b_delay / r_delay cycles.
  logic        s_aw_hs, s_ar_hs, s_b_hs, s_r_hs;
  logic [31:0] s_aw_a, s_aw_d, s_ar_a;
  logic [3:0]  s_aw_s;
  int          s_b_cnt = -1, s_r_cnt = -1;
  initial begin
    axi.m_b_valid = 1'b0; axi.m_b_resp = 2'b00;
    axi.m_r_valid = 1'b0; axi.m_r_data = 32'd0; axi.m_r_resp = 2'b00;
    forever begin
      @(negedge clk);
      s_aw_hs = axi.m_aw_valid && axi.m_aw_ready;
      s_ar_hs = axi.m_ar_valid && axi.m_ar_ready;
      s_b_hs  = axi.m_b_valid && axi.m_b_ready;
      s_r_hs  = axi.m_r_valid && axi.m_r_ready;
      s_aw_a = axi.m_aw_addr; s_aw_d = axi.m_aw_data; s_aw_s = axi.m_aw_strb;
      s_ar_a = axi.m_ar_addr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        axi.m_b_valid = 1'b0; axi.m_r_valid = 1'b0; s_b_cnt = -1; s_r_cnt = -1;
      end else begin
        if (s_aw_hs) begin
          slv_mem[s_aw_a[5:2]] = merge(slv_mem[s_aw_a[5:2]], s_aw_d, s_aw_s);
          s_b_cnt = b_delay;
        end
        if (s_ar_hs) s_r_cnt = r_delay;
        if (s_b_hs) axi.m_b_valid = 1'b0;
        if (s_r_hs) axi.m_r_valid = 1'b0;
        if (s_b_cnt == 0) begin
          axi.m_b_valid = 1'b1; axi.m_b_resp = b_resp_val; s_b_cnt = -1;
        end else if (s_b_cnt > 0) s_b_cnt--;
        if (s_r_cnt == 0) begin
          axi.m_r_valid = 1'b1; axi.m_r_resp = r_resp_val;
          axi.m_r_data = slv_mem[s_ar_a[5:2]]; s_r_cnt = -1;
        end else if (s_r_cnt > 0) s_r_cnt--;
      end
    end
  end

  // Monitor: busy/cmd_ready vs outstanding, bus payload vs command, responses vs scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(outstanding));
      if (outstanding) chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (axi.m_aw_valid) begin
        chk("aw_is_write", 32'(cur_write), 32'd1);
        chk("aw_addr", axi.m_aw_addr, cur_addr);
        chk("aw_data", axi.m_aw_data, cur_wdata);
        chk("aw_strb", 32'(axi.m_aw_strb), 32'(cur_strb));
      end
      if (axi.m_ar_valid) begin
        chk("ar_is_read", 32'(cur_write), 32'd0);
        chk("ar_addr", axi.m_ar_addr, cur_addr);
      end
      if (axi.m_b_ready) chk("b_ready_ctx", 32'(outstanding && cur_write), 32'd1);
      if (axi.m_r_ready) chk("r_ready_ctx", 32'(outstanding && !cur_write), 32'd1);
      if (rsp_valid) begin
        chk("rsp_bus_idle", 32'({axi.m_aw_valid, axi.m_ar_valid, axi.m_b_ready, axi.m_r_ready}), 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=1, expected no response");
        end else begin
          chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
          chk("rsp_resp", 32'(rsp_resp), 32'(exp_q[0].resp));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_q[0].tmo));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) outstanding = 1'b1;
      else if (rsp_valid && rsp_ready) outstanding = 1'b0;
    end
  end

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input rsp_t e);
    int n;
    @(posedge clk);
    #1;
    cur_write = wr; cur_addr = a; cur_wdata = d; cur_strb = s;
    exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 50) abort("cmd_accept");
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish(input int rdly, output int lat);
    lat = 0;
    rsp_ready = (rdly == 0);
    do begin
      @(negedge clk);
      lat++;
      if (lat > 600) abort("rsp_wait");
    end while (!rsp_valid);
    if (rdly > 0) begin
      for (int k = 1; k < rdly; k++) begin
        @(posedge clk);
        @(negedge clk);
        chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    abort("global_watchdog");
  end

  initial begin
    int lat;
    int n;
    for (int i = 0; i < 16; i++) begin model_mem[i] = 32'd0; slv_mem[i] = 32'd0; end
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0; cmd_strb = 4'd0;
    rsp_ready = 1'b0;
    axi.m_aw_ready = 1'b1; axi.m_ar_ready = 1'b1;
    #12;
    chk("reset_ctrl", 32'({cmd_ready, rsp_valid, rsp_timeout, busy, axi.m_aw_valid,
                           axi.m_ar_valid, axi.m_b_ready, axi.m_r_ready, rsp_resp}), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_aw_payload", axi.m_aw_addr | axi.m_aw_data | 32'(axi.m_aw_strb), 32'd0);
    chk("reset_ar_addr", axi.m_ar_addr, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue(1'b1, 32'h0, 32'd12, 4'hF, wr_exp(32'h0, 32'd12, 4'hF));
    finish(0, lat);
    chk("wr_latency", 32'(lat), 32'd3);
    issue(1'b0, 32'h0, 32'd0, 4'h0, rd_exp(32'h0));
    finish(0, lat);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd0_literal", rsp_rdata, 32'd12);
    issue(1'b1, 32'h4, 32'h0000ABCD, 4'hF, wr_exp(32'h4, 32'h0000ABCD, 4'hF));
    finish(0, lat);
    issue(1'b0, 32'h4, 32'd0, 4'h0, rd_exp(32'h4));
    finish(0, lat);
    chk("rd4_literal", rsp_rdata, 32'h0000ABCD);

    issue(1'b1, 32'h8, 32'h11223344, 4'hF, wr_exp(32'h8, 32'h11223344, 4'hF));
    finish(0, lat);
    b_resp_val = 2'b01;
    issue(1'b1, 32'h8, 32'hAABBCCDD, 4'h5, wr_exp(32'h8, 32'hAABBCCDD, 4'h5));
    finish(0, lat);
    chk("wr_bresp_literal", 32'(rsp_resp), 32'd1);
    b_resp_val = 2'b00;
    issue(1'b0, 32'h8, 32'd0, 4'h0, rd_exp(32'h8));
    finish(0, lat);
    chk("strb_merge_literal", rsp_rdata, 32'h11BB33DD);

    @(posedge clk);
    #1;
    axi.m_aw_ready = 1'b0;
    b_delay = 2;
    issue(1'b1, 32'hC, 32'hDEADBEEF, 4'hF, wr_exp(32'hC, 32'hDEADBEEF, 4'hF));
    repeat (5) begin
      @(negedge clk);
      chk("aw_hold", 32'(axi.m_aw_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    axi.m_aw_ready = 1'b1;
    finish(0, lat);
    b_delay = 0;

    @(posedge clk);
    #1;
    axi.m_ar_ready = 1'b0;
    r_delay = 3;
    r_resp_val = 2'b11;
    issue(1'b0, 32'hC, 32'd0, 4'h0, rd_exp(32'hC));
    repeat (5) begin
      @(negedge clk);
      chk("ar_hold", 32'(axi.m_ar_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    axi.m_ar_ready = 1'b1;
    finish(0, lat);
    chk("rd_stall_literal", rsp_rdata, 32'hDEADBEEF);
    r_delay = 0;
    r_resp_val = 2'b00;

    issue(1'b0, 32'h4, 32'd0, 4'h0, rd_exp(32'h4));
    finish(4, lat);

    @(posedge clk);
    #1;
    axi.m_ar_ready = 1'b0;
`ifdef NEBULA_AXIL_MST_TIMEOUT_EN
    issue(1'b0, 32'h8, 32'd0, 4'h0, {32'd0, 2'b10, 1'b1});
    finish(0, lat);
    chk("tmo_latency", 32'(lat), 32'(TMO + 1));
    chk("tmo_flag_literal", 32'(rsp_timeout), 32'd1);
    @(posedge clk);
    #1;
    axi.m_ar_ready = 1'b1;
`else
    issue(1'b0, 32'h8, 32'd0, 4'h0, rd_exp(32'h8));
    repeat (TMO + 40) begin
      @(negedge clk);
      chk("busy_wait", 32'({busy, axi.m_ar_valid, rsp_valid}), 32'd6);
    end
    @(posedge clk);
    #1;
    axi.m_ar_ready = 1'b1;
    finish(0, lat);
    chk("no_tmo_literal", rsp_rdata, 32'h11BB33DD);
`endif

    r_delay = 10;
    issue(1'b0, 32'h4, 32'd0, 4'h0, rd_exp(32'h4));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 50) abort("r_ready_wait");
    end while (!axi.m_r_ready);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 32'({cmd_ready, rsp_valid, rsp_timeout, busy, axi.m_aw_valid,
                            axi.m_ar_valid, axi.m_b_ready, axi.m_r_ready, rsp_resp}), 32'd0);
    chk("midrst_rdata", rsp_rdata, 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r_delay = 0;
    issue(1'b0, 32'h4, 32'd0, 4'h0, rd_exp(32'h4));
    finish(0, lat);
    chk("post_rst_literal", rsp_rdata, 32'h0000ABCD);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nebula_axil_master.md
Name: nebula_axil_master

Overview:
- AXI-Lite initiator. Converts single-beat command requests from on-chip control logic into AXI-Lite transactions toward register slaves such as nebula_axil_regs.
- Uses the team's combined address+data write channel (AW and W carried together), a read address channel, and separate B and R response channels.
- At most one transaction outstanding. Response returned on a valid/ready response port.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; DATA_W/8 strobe bits
- TIMEOUT_CYCLES, 256, cycles from command accept to abort (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  write strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  AXI resp code
- rsp_timeout  out  1  transaction aborted by timeout
- busy  out  1  state != IDLE
- m_aw_valid  out  1  write address+data valid
- m_aw_ready  in  1
- m_aw_addr  out  ADDR_W
- m_aw_data  out  DATA_W
- m_aw_strb  out  DATA_W/8
- m_b_valid  in  1
- m_b_ready  out  1
- m_b_resp  in  2
- m_ar_valid  out  1
- m_ar_ready  in  1
- m_ar_addr  out  ADDR_W
- m_r_valid  in  1
- m_r_ready  out  1
- m_r_data  in  DATA_W
- m_r_resp  in  2

Behaviour:
- Reset: all outputs 0; address, data and strobe registers 0; state IDLE.
- Reset mid-transaction: all valid and ready outputs drop immediately; no partial response is issued.
- State machine: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr, wdata and strb, and clear the timeout counter.
  - Go to WR_REQ if cmd_write=1, else RD_REQ.
- WR_REQ:
  - m_aw_valid=1, with addr, data and strb driven from the latched registers.
  - On m_aw_ready, go to WR_RESP.
- WR_RESP:
  - m_b_ready=1.
  - On m_b_valid, latch m_b_resp, set rdata=0 and timeout=0, then go to RSP.
- RD_REQ:
  - m_ar_valid=1.
  - On m_ar_ready, go to RD_DATA.
- RD_DATA:
  - m_r_ready=1.
  - On m_r_valid, latch m_r_data and m_r_resp, set timeout=0, then go to RSP.
- RSP:
  - rsp_valid=1 with rsp_* fields stable.
  - On rsp_ready, go to IDLE.
  - cmd_ready=0 until the next cycle in IDLE, so back-to-back commands are spaced by at least one IDLE cycle.
- AXI rules:
  - A valid, once raised, holds with stable payload until its ready is seen.
  - The ready for a response channel is asserted only in that channel's response state. A B or R beat arriving in the same cycle as the address handshake is taken in the following cycle.
  - Unsolicited B or R beats in any other state are ignored (ready low).
- Minimum latency, zero-wait slave: accept at cycle 0, address handshake at cycle 1, response at cycle 2, rsp_valid at cycle 3.
- Response outputs are registered and hold their value until the next response is loaded.

Optional Feature:
- Macro: NEBULA_AXIL_MST_TIMEOUT_EN
- With the macro:
  - A counter increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - When it reaches TIMEOUT_CYCLES-1 without completion, the next state is RSP with rsp_resp=2'b10, rsp_timeout=1 and rsp_rdata=0.
  - Channel valid and ready outputs drop at that point. This is a documented abort; the slave is treated as failed.
  - If completion and timeout occur in the same cycle, completion wins.
- Without the macro: no counter; the block waits indefinitely and rsp_timeout is tied to 0.

Test Plan:
- Write addr 0x0, data 12, strb 0xF, zero-wait slave model -> m_aw_* carries 0x0/12/0xF for one cycle; rsp_valid at cycle 3 with resp=0, rdata=0.
- Read addr 0x0 after the write above -> m_ar_addr=0x0; rsp_rdata=12, resp=0. Then write 0x4=0xABCD and read 0x4 -> rdata=0xABCD.
- m_aw_ready held low 5 cycles -> m_aw_valid stays 1 with addr, data and strb unchanged; completion follows the first ready. Same check for m_ar_valid.
- rsp_ready held low 4 cycles -> rsp fields stable and cmd_ready=0 throughout; cmd_ready=1 the cycle after rsp_ready.
- Timeout enabled, TIMEOUT_CYCLES=16, m_ar_ready never asserted -> after 16 cycles rsp_valid=1, rsp_resp=2'b10, rsp_timeout=1, m_ar_valid=0. Timeout disabled -> busy stays 1 indefinitely.
- rst_n asserted in RD_DATA -> all outputs 0 immediately; after release, a read of 0x4 completes normally.
